inbuf_skew_seq: RTL and testbench
=================================

// Module: inbuf_skew_seq
// PURPOSE
//   Sequencer sitting directly downstream-side of the per-row input buffers (INBUF) of the systolic array.
//   Issues staggered read strobes so row i starts i cycles after row 0 (diagonal wavefront skew).
//   Produces per-row valid flags aligned to the buffers' registered dout, plus busy/done handshake.
//   Pure control: the buffer data path does not pass through this block.
// PARAMETERS
//   ROWS  = 4   number of INBUF rows driven (>=1)
//   CNTW  = 5   width of the per-row word-count field len (max len = 2**CNTW-1)
// PORTS
//   clk        in   1         clock, rising edge
//   rstn       in   1         reset, asynchronous, active-low
//   start      in   1         begin a pass; sampled only in IDLE
//   len        in   CNTW      words to read per row; sampled with start
//   stall      in   1         hold sequencing (present only with INBUF_SKEW_STALL_EN)
//   rd         out  ROWS      read strobe to INBUF[i]; one word per high cycle
//   vld        out  ROWS      INBUF[i].dout valid this cycle (= rd[i] delayed 1 cycle)
//   busy       out  1         high in RUN and DRAIN
//   done       out  1         one-cycle pulse after pass completes
// BEHAVIOUR
//   Reset (rstn=0, async): rd=0, vld=0, busy=0, done=0, state=IDLE, t=0, len_q=0. Reset mid-pass aborts silently.
//   States: IDLE -> RUN -> DRAIN -> IDLE.
//   IDLE: start=1 && len!=0 at edge -> latch len_q=len, t=0, enter RUN. start with len==0: ignored, stay IDLE, no done.
//   RUN: t counts cycles from 0; rd[i] = (t >= i) && (t < i+len_q), combinational from registered t/len_q.
//     Final RUN cycle is t = len_q+ROWS-2; then enter DRAIN. Counter width CNTW+$clog2(ROWS)+1, no overflow.
//   DRAIN: exactly one cycle, rd=0, vld[ROWS-1] carries last beat; next edge -> IDLE with done=1.
//   done: registered, high for exactly the first IDLE cycle after DRAIN; 0 otherwise.
//   vld: registered copy of rd (matches INBUF 1-cycle read latency); vld=0 in the cycle after any rd=0.
//   start while busy or during the done cycle's preceding DRAIN: ignored. start in the done cycle: accepted (back-to-back passes).
//   Total per pass: RUN len_q+ROWS-1 cycles, DRAIN 1, done 1 cycle later; each rd[i] high exactly len_q cycles total.
//   No empty/full checking: caller guarantees each INBUF holds >= len_q words before start.
//   ROWS=1: no skew, rd[0] high len_q consecutive cycles.
// CONFIGURATION
//   INBUF_SKEW_STALL_EN defined: stall port exists. In RUN with stall=1: rd=0 all rows, t holds,
//     next-cycle vld=0; sequence resumes unchanged when stall drops. stall ignored in IDLE/DRAIN.
//   INBUF_SKEW_STALL_EN undefined: no stall port; behaviour as if stall=0 always.
// TESTING
//   T1 reset: assert rstn=0 mid-RUN (ROWS=4,len=3,t=2) -> rd,vld,busy,done all 0 immediately; start after release works.
//   T2 ROWS=4,len=3 start: rd[0] high t=0..2, rd[3] high t=3..5; vld[i] = rd[i] +1 cycle; busy 7 cycles; done 1 cycle after.
//   T3 len=0 start -> no state change, busy=0, rd=0, done never pulses.
//   T4 back-to-back: len=2 then start asserted in done cycle with len=5 -> second pass begins, rd[0] high 5 cycles.
//   T5 start held high during RUN with different len -> ignored; per-row rd counts equal first len_q.
//   T6 (STALL_EN) ROWS=4,len=4, stall=1 for 2 cycles at t=2 -> rd=0 2 cycles, each rd[i] still high 4 cycles total, done delayed by 2.

Source files
------------

// File: rtl/inbuf_skew_seq.sv
// inbuf_skew_seq: issues diagonally skewed read strobes to the per-row input buffers of the systolic array.
// Define INBUF_SKEW_STALL_EN to add the stall input; without it the sequencer never stalls.
//
// state   | meaning
// S_IDLE  | waiting for start with a non-zero len; done pulses here for one cycle after a pass
// S_RUN   | t advances from 0 to len_q+ROWS-2, rd[i] high while i <= t < i+len_q
// S_DRAIN | one cycle with rd=0 so the last row's final word shows up on vld
module inbuf_skew_seq #(
  parameter int ROWS = 4,
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [CNTW-1:0] len,
`ifdef INBUF_SKEW_STALL_EN
  input  logic            stall,
`endif
  output logic [ROWS-1:0] rd,
  output logic [ROWS-1:0] vld,
  output logic            busy,
  output logic            done
);

  // Wide enough for len_q+ROWS-1 without wrapping.
  localparam int TW = CNTW + $clog2(ROWS) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   t_q;
  logic [CNTW-1:0] len_q;
  logic [ROWS-1:0] vld_q;
  logic            busy_q;
  logic            done_q;
  logic            stall_w;
  logic [TW-1:0]   len_ext;
  logic [TW-1:0]   t_last;
  logic [ROWS-1:0] rd_d;

`ifdef INBUF_SKEW_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign len_ext = TW'(len_q);
  // len_q is never zero while in RUN, so this cannot underflow even for ROWS=1.
  assign t_last  = len_ext + TW'(ROWS) - TW'(2);

  always_comb begin
    rd_d = '0;
    if (state_q == S_RUN && !stall_w) begin
      for (int i = 0; i < ROWS; i++) begin
        rd_d[i] = (t_q >= TW'(i)) && (t_q < TW'(i) + len_ext);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      len_q   <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vld_q  <= rd_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && len != '0) begin
            len_q   <= len;
            t_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!stall_w) begin
            if (t_q == t_last) begin
              state_q <= S_DRAIN;
            end else begin
              t_q <= t_q + TW'(1);
            end
          end
        end
        S_DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd   = rd_d;
  assign vld  = vld_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_inbuf_skew_seq.sv
// tb_inbuf_skew_seq: directed and random passes checked against a per-cycle expected timeline.
// The timeline is filled from pass rules (row i reads cycles start+1+i .. start+i+len) and shifted on stalls.
module tb_inbuf_skew_seq;

  localparam int ROWS = 4;
  localparam int CNTW = 5;
  localparam int MAXC = 1024;
`ifdef INBUF_SKEW_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic [CNTW-1:0] len = '0;
`ifdef INBUF_SKEW_STALL_EN
  logic            stall = 1'b0;
`endif
  logic [ROWS-1:0] rd;
  logic [ROWS-1:0] vld;
  logic            busy;
  logic            done;

  inbuf_skew_seq #(.ROWS(ROWS), .CNTW(CNTW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .start(start),
    .len  (len),
`ifdef INBUF_SKEW_STALL_EN
    .stall(stall),
`endif
    .rd   (rd),
    .vld  (vld),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  logic [ROWS-1:0] e_rd   [MAXC];
  bit              e_busy [MAXC];
  bit              e_done [MAXC];
  int cyc;
  int free_at;
  int run_beg;
  int run_end;
  int n_chk;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic schedule(input int l);
    run_beg = cyc + 1;
    run_end = cyc + l + ROWS - 1;
    free_at = cyc + l + ROWS + 1;
    for (int k = cyc + 1; k <= cyc + l + ROWS && k < MAXC; k++) e_busy[k] = 1'b1;
    if (free_at < MAXC) e_done[free_at] = 1'b1;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < l; j++)
        if (cyc + 1 + i + j < MAXC) e_rd[cyc + 1 + i + j][i] = 1'b1;
  endtask

  // A stall in a RUN cycle pushes everything from this cycle on one cycle later.
  task automatic apply_stall();
    for (int k = MAXC - 1; k > cyc; k--) begin
      e_rd[k]   = e_rd[k-1];
      e_busy[k] = e_busy[k-1];
      e_done[k] = e_done[k-1];
    end
    e_rd[cyc] = '0;
    run_end++;
    free_at++;
  endtask

  task automatic step(input bit s, input int l, input bit st);
    start = s;
    len   = CNTW'(l);
`ifdef INBUF_SKEW_STALL_EN
    stall = st;
`endif
    if (HAS_STALL && st && cyc >= run_beg && cyc <= run_end) apply_stall();
    if (s && l != 0 && cyc >= free_at) schedule(l);
    #1;
    chk("rd",   32'(rd),   32'(e_rd[cyc]));
    chk("vld",  32'(vld),  (cyc > 0) ? 32'(e_rd[cyc-1]) : 32'd0);
    chk("busy", 32'(busy), 32'(e_busy[cyc]));
    chk("done", 32'(done), 32'(e_done[cyc]));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    start = 1'b0;
    rstn  = 1'b0;
    #1;
    chk("arst_rd",   32'(rd),   32'd0);
    chk("arst_vld",  32'(vld),  32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    for (int k = cyc; k < MAXC; k++) begin
      e_rd[k]   = '0;
      e_busy[k] = 1'b0;
      e_done[k] = 1'b0;
    end
    free_at = cyc;
    run_beg = 0;
    run_end = -1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rstn = 1'b1;
  endtask

  initial begin
    int l;
    bit s;
    bit st;
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    free_at = 0;
    run_beg = 0;
    run_end = -1;
    for (int k = 0; k < MAXC; k++) begin
      e_rd[k]   = '0;
      e_busy[k] = 1'b0;
      e_done[k] = 1'b0;
    end

    @(negedge clk);
    chk("rst_rd",   32'(rd),   32'd0);
    chk("rst_vld",  32'(vld),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;

    // reset in the middle of a len=3 pass at t=2
    step(1'b1, 3, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    do_reset();

    // plain pass, len=3
    step(1'b1, 3, 1'b0);
    repeat (9) step(1'b0, 0, 1'b0);

    // len=0 is ignored
    step(1'b1, 0, 1'b0);
    repeat (3) step(1'b0, 0, 1'b0);

    // back-to-back: second start lands in the done cycle
    step(1'b1, 2, 1'b0);
    for (int g = 0; g < 20 && cyc < free_at; g++) step(1'b0, 0, 1'b0);
    step(1'b1, 5, 1'b0);
    repeat (12) step(1'b0, 0, 1'b0);

    // start held with a different len while busy
    step(1'b1, 3, 1'b0);
    repeat (7) step(1'b1, 7, 1'b0);
    step(1'b0, 0, 1'b0);
    repeat (3) step(1'b0, 0, 1'b0);

    if (HAS_STALL) begin
      // len=4, two stall cycles at t=2
      step(1'b1, 4, 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      repeat (12) step(1'b0, 0, 1'b0);
    end

    repeat (600) begin
      s = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       l = 0;
        1:       l = 31;
        default: l = int'($urandom_range(1, 6));
      endcase
      st = HAS_STALL && ($urandom_range(0, 4) == 0);
      step(s, l, st);
    end
    repeat (50) step(1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
